// File: rtl/sound_scheduler.sv
// Sound scheduler: edge-detects good/bad collision and direction events, keeps one
// pending tone per source and plays them by fixed priority with preemption and a gap.
module sound_scheduler #(
    parameter int unsigned TONE_LEN = 1200000,
    parameter int unsigned GAP_LEN  = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       goodColl_i,
    input  logic       badColl_i,
    input  logic [3:0] direction_i,
    output logic [7:0] freq_o,
    output logic       tone_o,
    output logic       busy_o,
    output logic [1:0] src_o
);
    localparam logic [23:0] TONE_RELOAD = 24'(TONE_LEN - 1);
    localparam logic [23:0] GAP_RELOAD  = 24'(GAP_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    // Source codes double as priority: 3 direction > 2 bad > 1 good > 0 none.
    function automatic logic [7:0] div_of(input logic [1:0] src);
        case (src)
            2'd1:    div_of = 8'd107;
            2'd2:    div_of = 8'd151;
            2'd3:    div_of = 8'd179;
            default: div_of = 8'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] src);
        case (src)
            2'd1:    onehot = 3'b001;
            2'd2:    onehot = 3'b010;
            2'd3:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  prev_q;
    logic [2:0]  pend_q, pend_d;
    logic [1:0]  src_q, src_d;
    logic [23:0] dur_q, dur_d;
    logic [14:0] hp_q, hp_d;
    logic        tone_q, tone_d;

    logic [2:0]  in_now, edge_w, cur_mask;
    logic [1:0]  best;
    logic [14:0] hp_term;
    logic        retrig, start;

    assign in_now   = {|direction_i, badColl_i, goodColl_i};
    assign edge_w   = in_now & ~prev_q;
    assign cur_mask = (state_q == S_PLAY) ? onehot(src_q) : 3'b000;
    assign retrig   = |(edge_w & cur_mask);
    assign hp_term  = {div_of(src_q), 7'd0} - 15'd1;

    // Selection looks only at registered pending bits, so a new edge costs one cycle.
    always_comb begin
        best = 2'd0;
        if (pend_q[2])      best = 2'd3;
        else if (pend_q[1]) best = 2'd2;
        else if (pend_q[0]) best = 2'd1;
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dur_d   = dur_q;
        hp_d    = hp_q;
        tone_d  = tone_q;
        pend_d  = pend_q | (edge_w & ~cur_mask);
        start   = 1'b0;
        case (state_q)
            S_IDLE: start = (best != 2'd0);
            S_PLAY: begin
                if (best > src_q) begin
                    start = 1'b1;
                end else if (!retrig && dur_q == 24'd0) begin
                    state_d = S_GAP;
                    dur_d   = GAP_RELOAD;
                    src_d   = 2'd0;
                    hp_d    = 15'd0;
                    tone_d  = 1'b0;
                end else begin
                    dur_d = retrig ? TONE_RELOAD : dur_q - 24'd1;
                    if (hp_q == hp_term) begin
                        hp_d   = 15'd0;
                        tone_d = ~tone_q;
                    end else begin
                        hp_d = hp_q + 15'd1;
                    end
                end
            end
            S_GAP: begin
                if (dur_q == 24'd0) begin
                    if (best != 2'd0) start = 1'b1;
                    else              state_d = S_IDLE;
                end else begin
                    dur_d = dur_q - 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A takeover discards the current tone; only the winner's pending bit clears.
        if (start) begin
            state_d = S_PLAY;
            src_d   = best;
            dur_d   = TONE_RELOAD;
            hp_d    = 15'd0;
            tone_d  = 1'b0;
            pend_d  = pend_d & ~onehot(best);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prev_q  <= in_now;
            pend_q  <= 3'b000;
            src_q   <= 2'd0;
            dur_q   <= 24'd0;
            hp_q    <= 15'd0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= in_now;
            pend_q  <= pend_d;
            src_q   <= src_d;
            dur_q   <= dur_d;
            hp_q    <= hp_d;
            tone_q  <= tone_d;
        end
    end

    assign freq_o = (state_q == S_PLAY) ? div_of(src_q) : 8'd0;
    assign tone_o = tone_q;
    assign busy_o = (state_q != S_IDLE);
    assign src_o  = src_q;
endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: a long-tone instance checked against fixed timings and a
// short-tone instance checked every cycle against an event-level reference model.
module tb_sound_scheduler;
    localparam int S_TONE = 600;
    localparam int S_GAP  = 16;
    localparam int L_TONE = 40000;
    localparam int L_GAP  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       g_s, b_s, g_l, b_l;
    logic [3:0] d_s, d_l;
    logic [7:0] f_s, f_l;
    logic       t_s, t_l, bz_s, bz_l;
    logic [1:0] s_s, s_l;

    int n_chk = 0;
    int n_err = 0;

    sound_scheduler #(.TONE_LEN(S_TONE), .GAP_LEN(S_GAP)) u_dut (
        .clk(clk), .rst(rst), .goodColl_i(g_s), .badColl_i(b_s), .direction_i(d_s),
        .freq_o(f_s), .tone_o(t_s), .busy_o(bz_s), .src_o(s_s));

    sound_scheduler #(.TONE_LEN(L_TONE), .GAP_LEN(L_GAP)) u_long (
        .clk(clk), .rst(rst), .goodColl_i(g_l), .badColl_i(b_l), .direction_i(d_l),
        .freq_o(f_l), .tone_o(t_l), .busy_o(bz_l), .src_o(s_l));

    // Reference model state for the short instance: mode 0 idle, 1 playing, 2 gap.
    int m_mode = 0, m_src = 0, m_left = 0, m_el = 0;
    bit m_pend[4];
    bit m_pg, m_pb, m_pd;

    function automatic int note_div(input int s);
        int f;
        f = (s == 1) ? 440 : (s == 2) ? 311 : 262;
        return (12000000 + f * 128) / (f * 256);
    endfunction

    function automatic logic [11:0] exp_out();
        int d;
        logic tn;
        if (m_mode == 1) begin
            d  = note_div(m_src);
            tn = ((m_el / (d * 128)) % 2) == 1;
            return {8'(d), tn, 1'b1, 2'(m_src)};
        end
        if (m_mode == 2) return 12'h004;
        return 12'h000;
    endfunction

    task automatic m_start(input int s);
        m_mode = 1; m_src = s; m_left = S_TONE; m_el = 0; m_pend[s] = 0;
    endtask

    task automatic model_step(input logic r, input logic g, input logic b, input logic [3:0] d);
        bit ev[4];
        int best;
        bit re;
        if (r) begin
            m_mode = 0; m_src = 0; m_left = 0; m_el = 0;
            for (int s = 0; s < 4; s++) m_pend[s] = 0;
            m_pg = g; m_pb = b; m_pd = |d;
            return;
        end
        ev[0] = 0; ev[1] = g && !m_pg; ev[2] = b && !m_pb; ev[3] = (|d) && !m_pd;
        m_pg = g; m_pb = b; m_pd = |d;
        best = 0;
        for (int s = 1; s <= 3; s++) if (m_pend[s]) best = s;
        re = 0;
        for (int s = 1; s <= 3; s++)
            if (ev[s]) begin
                if (m_mode == 1 && m_src == s) re = 1;
                else m_pend[s] = 1;
            end
        case (m_mode)
            0: if (best != 0) m_start(best);
            1: begin
                if (best > m_src) m_start(best);
                else if (!re && m_left == 1) begin
                    m_mode = 2; m_left = S_GAP; m_src = 0; m_el = 0;
                end else begin
                    m_left = re ? S_TONE : m_left - 1;
                    m_el++;
                end
            end
            default: begin
                if (m_left == 1) begin
                    if (best != 0) m_start(best);
                    else m_mode = 0;
                end else m_left--;
            end
        endcase
    endtask

    task automatic drive(input logic r, input logic g, input logic b, input logic [3:0] d);
        rst = r; g_s = g; b_s = b; d_s = d;
        model_step(r, g, b, d);
    endtask

    task automatic test_reset();
        g_l = 0; b_l = 0; d_l = 4'd0;
        drive(1, 0, 0, 4'd0);
        @(negedge clk); drive(1, 0, 0, 4'd0);
        @(negedge clk);
        n_chk++;
        if ({f_s, t_s, bz_s, s_s} !== 12'h000) begin
            n_err++; $display("FAIL reset_short got %h exp 000", {f_s, t_s, bz_s, s_s});
        end
        n_chk++;
        if ({f_l, t_l, bz_l, s_l} !== 12'h000) begin
            n_err++; $display("FAIL reset_long got %h exp 000", {f_l, t_l, bz_l, s_l});
        end
        // Inputs already high through reset must not count as events.
        drive(1, 1, 0, 4'b0100);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); n_chk++;
            if ({f_s, t_s, bz_s, s_s} !== exp_out()) begin
                n_err++; $display("FAIL reset_held t=%0t got %h exp %h", $time, {f_s, t_s, bz_s, s_s}, exp_out());
            end
            drive(0, 1, 0, 4'b0100);
        end
        n_chk++;
        if (bz_s !== 1'b0) begin
            n_err++; $display("FAIL reset_held_busy got %b exp 0", bz_s);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 0, 0, 4'd0);
        end
    endtask

    task automatic test_long_tone();
        logic [11:0] e;
        @(negedge clk); g_l = 1; drive(0, 0, 0, 4'd0);
        @(negedge clk); n_chk++;
        if ({f_l, bz_l} !== 9'h000) begin
            n_err++; $display("FAIL long_latency got %h exp 000", {f_l, bz_l});
        end
        g_l = 0; drive(0, 0, 0, 4'd0);
        for (int k = 0; k <= L_TONE + L_GAP + 4; k++) begin
            @(negedge clk);
            if (k < L_TONE) e = {8'd107, (k >= 13696 && k < 27392), 1'b1, 2'd1};
            else if (k < L_TONE + L_GAP) e = 12'h004;
            else e = 12'h000;
            n_chk++;
            if ({f_l, t_l, bz_l, s_l} !== e) begin
                n_err++; $display("FAIL long_tone k=%0d got %h exp %h", k, {f_l, t_l, bz_l, s_l}, e);
            end
            drive(0, 0, 0, 4'd0);
        end
    endtask

    task automatic test_preempt_reset();
        logic [11:0] e;
        @(negedge clk); g_l = 1; drive(0, 0, 0, 4'd0);
        @(negedge clk); g_l = 0; drive(0, 0, 0, 4'd0);
        for (int k = 0; k <= 14001; k++) begin
            @(negedge clk);
            e = {8'd107, (k >= 13696), 1'b1, 2'd1};
            n_chk++;
            if ({f_l, t_l, bz_l, s_l} !== e) begin
                n_err++; $display("FAIL pre_good k=%0d got %h exp %h", k, {f_l, t_l, bz_l, s_l}, e);
            end
            b_l = (k == 14000);
            drive(0, 0, 0, 4'd0);
        end
        for (int j = 0; j <= 5000; j++) begin
            @(negedge clk);
            n_chk++;
            if ({f_l, t_l, bz_l, s_l} !== {8'd151, 1'b0, 1'b1, 2'd2}) begin
                n_err++; $display("FAIL pre_bad j=%0d got %h exp 974", j, {f_l, t_l, bz_l, s_l});
            end
            g_l = (j == 10);
            drive(j == 5000, 0, 0, 4'd0);
        end
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            n_chk++;
            if ({f_l, t_l, bz_l, s_l} !== 12'h000) begin
                n_err++; $display("FAIL mid_reset j=%0d got %h exp 000", j, {f_l, t_l, bz_l, s_l});
            end
            drive(j == 0, 0, 0, 4'd0);
        end
    endtask

    task automatic test_preempt();
        int c1 = 0, c2 = 0;
        for (int i = 0; i < 760; i++) begin
            @(negedge clk); n_chk++;
            if ({f_s, t_s, bz_s, s_s} !== exp_out()) begin
                n_err++; $display("FAIL preempt t=%0t got %h exp %h", $time, {f_s, t_s, bz_s, s_s}, exp_out());
            end
            if (s_s == 2'd1) c1++;
            if (s_s == 2'd2) c2++;
            drive(0, i == 0, i == 100, 4'd0);
        end
        n_chk++;
        if (c1 !== 100 || c2 !== S_TONE) begin
            n_err++; $display("FAIL preempt_len good %0d bad %0d exp 100 %0d", c1, c2, S_TONE);
        end
    endtask

    task automatic test_simultaneous();
        logic [23:0] seq = 24'd0;
        logic [7:0]  fp = 8'd0;
        int nseq = 0, ctone = 0, cgap = 0;
        for (int i = 0; i < 3 * (S_TONE + S_GAP) + 20; i++) begin
            @(negedge clk); n_chk++;
            if ({f_s, t_s, bz_s, s_s} !== exp_out()) begin
                n_err++; $display("FAIL simul t=%0t got %h exp %h", $time, {f_s, t_s, bz_s, s_s}, exp_out());
            end
            if (f_s != 8'd0 && fp == 8'd0) begin seq = {seq[15:0], f_s}; nseq++; end
            if (f_s != 8'd0) ctone++;
            if (bz_s && f_s == 8'd0) cgap++;
            fp = f_s;
            drive(0, i == 0, i == 0, (i == 0) ? 4'b0010 : 4'd0);
        end
        n_chk++;
        if (nseq !== 3 || seq !== {8'd179, 8'd151, 8'd107}) begin
            n_err++; $display("FAIL simul_order got %0d %h exp 3 b3976b", nseq, seq);
        end
        n_chk++;
        if (ctone !== 3 * S_TONE || cgap !== 3 * S_GAP || bz_s !== 1'b0) begin
            n_err++; $display("FAIL simul_len tone %0d gap %0d busy %b", ctone, cgap, bz_s);
        end
    endtask

    task automatic test_hold();
        int starts = 0;
        logic [7:0] fp = 8'd0;
        logic [3:0] d;
        for (int i = 0; i < 2800; i++) begin
            @(negedge clk); n_chk++;
            if ({f_s, t_s, bz_s, s_s} !== exp_out()) begin
                n_err++; $display("FAIL hold t=%0t got %h exp %h", $time, {f_s, t_s, bz_s, s_s}, exp_out());
            end
            if (f_s == 8'd179 && fp == 8'd0) starts++;
            fp = f_s;
            if (i == 2000) begin
                n_chk++;
                if (starts !== 1) begin
                    n_err++; $display("FAIL hold_once got %0d exp 1", starts);
                end
            end
            d = (i < 2000 || (i >= 2050 && i < 2060)) ? 4'b1000 : 4'd0;
            drive(0, 0, 0, d);
        end
        n_chk++;
        if (starts !== 2) begin
            n_err++; $display("FAIL hold_repress got %0d exp 2", starts);
        end
    endtask

    task automatic test_random();
        logic gl = 0, bl = 0;
        logic [3:0] dl = 4'd0;
        logic r;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk); n_chk++;
            if ({f_s, t_s, bz_s, s_s} !== exp_out()) begin
                n_err++; $display("FAIL random i=%0d got %h exp %h", i, {f_s, t_s, bz_s, s_s}, exp_out());
            end
            if ($urandom_range(0, 99) < 2) gl = ~gl;
            if ($urandom_range(0, 99) < 2) bl = ~bl;
            if ($urandom_range(0, 99) < 2) dl = (dl == 4'd0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r = ($urandom_range(0, 1999) == 0);
            drive(r, gl, bl, dl);
        end
    endtask

    initial begin
        test_reset();
        test_long_tone();
        test_preempt_reset();
        test_preempt();
        test_simultaneous();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter TONE_LEN, default 1200000: tone length in clk cycles (100 ms at 12 MHz); legal range 1..2^24-1.
REQ-002 Parameter GAP_LEN, default 120000: silent gap in clk cycles after each completed tone; legal range 1..2^24-1.
REQ-003 clk  in  1  12 MHz system clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 goodColl_i  in  1  good-collision event level.
REQ-006 badColl_i  in  1  bad-collision event level.
REQ-007 direction_i  in  4  direction buttons; an event is any nonzero value.
REQ-008 freq_o  out  8  current tone divisor; 0 = silent.
REQ-009 tone_o  out  1  square-wave speaker drive.
REQ-010 busy_o  out  1  high while in PLAY or GAP.
REQ-011 src_o  out  2  playing source: 0 none, 1 good, 2 bad, 3 direction.

Function
REQ-012 Events SHALL be rising-edge detected against the previous sampled value: goodColl_i, badColl_i, and |direction_i. A held level SHALL produce exactly one event.
REQ-013 Each source SHALL have one pending bit, set on that source's event edge and cleared when that source enters PLAY. Repeated edges while pending SHALL NOT queue extra tones.
REQ-014 Fixed priority SHALL be direction (179) > bad (151) > good (107). Each divisor SHALL equal 12e6 / (f_note * 256) for C 262 Hz, D# 311 Hz and A 440 Hz respectively.
REQ-015 The FSM SHALL have three states: IDLE, PLAY and GAP.
REQ-016 IDLE with any pending bit SHALL go to PLAY on the next edge, selecting the highest-priority pending source. freq_o and src_o SHALL be valid on the second rising edge after the input is first sampled high.
REQ-017 PLAY SHALL last exactly TONE_LEN cycles, counted by a 24-bit down-counter, and SHALL then go to GAP.
REQ-018 GAP SHALL last exactly GAP_LEN cycles with freq_o=0, tone_o=0 and src_o=0.
REQ-019 At the end of GAP the FSM SHALL go to PLAY if any bit is pending, otherwise to IDLE.
REQ-020 Pending events SHALL NOT interrupt GAP.
REQ-021 Preemption: in PLAY, a pending source of strictly higher priority than src_o SHALL take over on the next edge. On takeover the duration counter SHALL reload to TONE_LEN and the half-period counter and tone_o SHALL reset to 0. The preempted tone SHALL be discarded, not re-queued.
REQ-022 Retrigger: an edge from the currently playing source SHALL reload the duration counter to TONE_LEN and SHALL NOT set its pending bit.
REQ-023 A lower-priority edge during PLAY SHALL only set its pending bit.
REQ-024 Tone generation: a 15-bit half-period counter SHALL count 0..freq_o*128-1 in PLAY. At terminal count, tone_o SHALL toggle and the counter SHALL return to 0. The resulting period SHALL be freq_o*256 cycles.
REQ-025 When multiple edges arrive in the same cycle, all corresponding pending bits SHALL be set, and they SHALL then be served strictly in priority order, each followed by a GAP.
REQ-026 busy_o SHALL be 1 in PLAY and GAP and 0 in IDLE.
REQ-027 freq_o SHALL be 0 outside PLAY.

Reset
REQ-028 rst sampled high SHALL force, on that edge: state IDLE, freq_o=0, tone_o=0, busy_o=0, src_o=0, all pending bits 0, all counters 0.
REQ-029 The previous-input registers SHALL load the current input values on the reset edge, so inputs already high during reset SHALL NOT generate events afterwards.
REQ-030 Reset in mid-PLAY or mid-GAP SHALL abandon the tone and all queued events without any further output.

Verification (bench parameters TONE_LEN=40000, GAP_LEN=16)
REQ-031 Assert rst 2 cycles with all inputs 0 -> freq_o=0, tone_o=0, busy_o=0, src_o=0.
REQ-032 One-cycle goodColl_i pulse -> freq_o=107 and src_o=1 two edges later; tone_o rises after 13696 PLAY cycles and falls after 27392; after 40000 cycles, 16 cycles with freq_o=0 and busy_o=1; then IDLE with busy_o=0.
REQ-033 goodColl_i pulse, then badColl_i pulse 100 cycles later -> freq_o switches 107->151 with tone_o reset to 0; 151 held 40000 cycles; GAP, then IDLE; good never replays.
REQ-034 goodColl_i, badColl_i and direction_i=4'b0010 in the same cycle -> sequence 179, GAP, 151, GAP, 107, GAP, IDLE; each tone lasts exactly 40000 cycles.
REQ-035 direction_i=4'b1000 held 200000 cycles -> exactly one 179 tone; a second tone only after release and re-press.
REQ-036 rst asserted 5000 cycles into a 151 tone with good pending -> next edge all outputs 0; after rst deasserts, nothing plays without a new edge.
